svn_seg_scan: RTL and testbench

- Parametrised successor to the two-digit static seven-segment decoder.
- Converts a binary value to BCD with a sequential double-dabble engine, then drives DIGITS common-anode digits by time-multiplexed scanning.
- Adds leading-zero blanking, per-digit decimal points and an overflow indication.
- Sits between any binary counter/score register and the board's shared segment bus and anode lines.

---
 rtl/svn_seg_scan.sv | 174 +++++++++++++++++
 tb/tb_svn_seg_scan.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/svn_seg_scan.sv
// Binary-to-BCD (sequential double-dabble) converter driving a time-multiplexed
// common-anode seven-segment display with leading-zero blanking, dp and overflow.
module svn_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int VAL_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int NBCD  = (VAL_W + 2) / 3;
  localparam int PADD  = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BIT_W = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_SHIFT} state_t;

  state_t                  state_reg, state_next;
  logic [VAL_W-1:0]        sr_reg;
  logic [NBCD*4-1:0]       bcd_reg;
  logic [BIT_W-1:0]        bit_reg;
  logic [DIGITS*4-1:0]     disp_reg;
  logic                    ovf_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [7:0]              seg_reg, seg_next;
  logic [DIGITS-1:0]       an_reg, an_next;

  logic [NBCD*4-1:0]       bcd_adj, bcd_shift;
  logic [PADD*4-1:0]       bcd_pad;
  logic                    ovf_new;
  logic                    last_bit;

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next MSB.
  for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end
  assign bcd_shift = {bcd_adj[NBCD*4-2:0], sr_reg[VAL_W-1]};

  always_comb begin
    bcd_pad = '0;
    bcd_pad[NBCD*4-1:0] = bcd_shift;
  end

  if (NBCD > DIGITS) begin : g_ovf
    assign ovf_new = |bcd_shift[NBCD*4-1:DIGITS*4];
  end else begin : g_no_ovf
    assign ovf_new = 1'b0;
  end

  assign last_bit = (bit_reg == BIT_W'(VAL_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (load) state_next = S_CAPT;
      S_CAPT:  state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg == S_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      bcd_reg  <= '0;
      bit_reg  <= '0;
      disp_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (load) sr_reg <= value;
        S_CAPT: begin
          bcd_reg <= '0;
          bit_reg <= '0;
        end
        S_SHIFT: begin
          bcd_reg <= bcd_shift;
          sr_reg  <= sr_reg << 1;
          bit_reg <= bit_reg + 1'b1;
          // Final step commits all digits and overflow in one edge.
          if (last_bit) begin
            disp_reg <= bcd_pad[DIGITS*4-1:0];
            ovf_reg  <= ovf_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign overflow = ovf_reg;

  // Scan timing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // zero_up[i]: digit i and every digit above it are zero.
  logic [3:0]        digit_arr [DIGITS];
  logic [DIGITS:0]   zero_up;
  logic [DIGITS-1:0] blank_vec;
  assign zero_up[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    assign digit_arr[gi] = disp_reg[gi*4 +: 4];
    assign zero_up[gi]   = (disp_reg[gi*4 +: 4] == 4'd0) && zero_up[gi+1];
    assign blank_vec[gi] = (LZ_BLANK != 0) && (gi > 0) && zero_up[gi];
  end

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0: enc7 = 7'h40;
      4'd1: enc7 = 7'h79;
      4'd2: enc7 = 7'h24;
      4'd3: enc7 = 7'h30;
      4'd4: enc7 = 7'h19;
      4'd5: enc7 = 7'h12;
      4'd6: enc7 = 7'h02;
      4'd7: enc7 = 7'h78;
      4'd8: enc7 = 7'h00;
      4'd9: enc7 = 7'h10;
      default: enc7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    seg_next = 8'hFF;
    if (ovf_reg)                 seg_next[6:0] = 7'h3F;
    else if (blank_vec[idx_reg]) seg_next[6:0] = 7'h7F;
    else                         seg_next[6:0] = enc7(digit_arr[idx_reg]);
    seg_next[7] = ~dp_mask[idx_reg];
    an_next = ~(DIGITS'(1) << idx_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_reg <= 8'hFF;
      an_reg  <= '1;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_svn_seg_scan.sv
// Directed bench for svn_seg_scan: one instance with leading-zero blanking,
// one without, sharing all inputs.
module tb_svn_seg_scan;
  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        busy, overflow, busy0, overflow0;
  logic [7:0]  seg, seg0;
  logic [3:0]  an, an0;
  int          checks = 0;
  int          errors = 0;
  int          bc;

  svn_seg_scan #(.DIGITS(4), .VAL_W(14), .SCAN_DIV(4), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask),
    .busy(busy), .overflow(overflow), .seg(seg), .an(an));

  svn_seg_scan #(.DIGITS(4), .VAL_W(14), .SCAN_DIV(4), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask),
    .busy(busy0), .overflow(overflow0), .seg(seg0), .an(an0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until the selected digit is being driven, then check its segments.
  task automatic chk_digit(input bit which, input int d, input logic [7:0] exp, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (((which ? an0 : an) !== want) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, which ? an0 : an, want);
    chk(tag, which ? seg0 : seg, exp);
  endtask

  task automatic do_load(input logic [13:0] v, output int bcnt);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcnt = 0;
    repeat (30) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("scan_an0", an, 4'b1110);
    repeat (4) @(negedge clk);
    chk("scan_an1", an, 4'b1101);
    repeat (4) @(negedge clk);
    chk("scan_an2", an, 4'b1011);
    repeat (4) @(negedge clk);
    chk("scan_an3", an, 4'b0111);
    repeat (4) @(negedge clk);
    chk("scan_wrap", an, 4'b1110);

    chk_digit(0, 0, 8'hC0, "zero_d0");
    chk_digit(0, 1, 8'hFF, "zero_d1");
    chk_digit(0, 2, 8'hFF, "zero_d2");
    chk_digit(0, 3, 8'hFF, "zero_d3");

    do_load(14'd1234, bc);
    chk("busy_len", bc, 14);
    chk("v1234_ovf", overflow, 1'b0);
    chk_digit(0, 0, 8'h99, "v1234_d0");
    chk_digit(0, 1, 8'hB0, "v1234_d1");
    chk_digit(0, 2, 8'hA4, "v1234_d2");
    chk_digit(0, 3, 8'hF9, "v1234_d3");

    do_load(14'd7, bc);
    chk_digit(0, 0, 8'hF8, "v7_d0");
    chk_digit(0, 1, 8'hFF, "v7_d1");
    chk_digit(0, 3, 8'hFF, "v7_d3");
    chk_digit(1, 0, 8'hF8, "v7_nolz_d0");
    chk_digit(1, 1, 8'hC0, "v7_nolz_d1");
    chk_digit(1, 2, 8'hC0, "v7_nolz_d2");
    chk_digit(1, 3, 8'hC0, "v7_nolz_d3");

    do_load(14'd10000, bc);
    chk("v10000_ovf", overflow, 1'b1);
    chk_digit(0, 0, 8'hBF, "v10000_d0");
    chk_digit(0, 1, 8'hBF, "v10000_d1");
    chk_digit(0, 2, 8'hBF, "v10000_d2");
    chk_digit(0, 3, 8'hBF, "v10000_d3");

    do_load(14'd9999, bc);
    chk("v9999_busy_len", bc, 14);
    chk("v9999_ovf", overflow, 1'b0);
    chk_digit(0, 0, 8'h90, "v9999_d0");
    chk_digit(0, 3, 8'h90, "v9999_d3");

    // Second load while busy must be ignored.
    @(negedge clk);
    value = 14'd1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    value = 14'd5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (25) @(negedge clk);
    chk("ign_busy", busy, 1'b0);
    chk_digit(0, 0, 8'h99, "ign_d0");
    chk_digit(0, 1, 8'hB0, "ign_d1");
    chk_digit(0, 2, 8'hA4, "ign_d2");
    chk_digit(0, 3, 8'hF9, "ign_d3");

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 14'd5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk_digit(0, 0, 8'hC0, "mid_d0");
    chk_digit(0, 1, 8'hFF, "mid_d1");
    chk_digit(0, 2, 8'hFF, "mid_d2");
    chk_digit(0, 3, 8'hFF, "mid_d3");

    dp_mask = 4'b0010;
    do_load(14'd7, bc);
    chk_digit(0, 1, 8'h7F, "dp_d1");
    chk_digit(0, 0, 8'hF8, "dp_d0");
    chk_digit(1, 1, 8'h40, "dp_nolz_d1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
